// File: rtl/pio_pkg.sv
// Shared constants for the input PIO family.
//   ADDR_*  : word addresses of the Avalon-MM register map
//   EDGE_*  : encodings for the EDGE_MODE parameter of pio_in_edge_irq
package pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a stability counter.
//   clk, reset_n : system clock, asynchronous active-low reset
//   in_bit       : raw asynchronous input
//   stable       : debounced, synchronised level
// A change on the synchronised input is accepted only after it has been seen on
// DEBOUNCE_CYCLES consecutive clocks; DEBOUNCE_CYCLES = 0 bypasses the counter.
module pio_debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic stable
);

   logic sync1_q;
   logic synced_q;
   logic stable_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         synced_q <= 1'b0;
      end else begin
         sync1_q  <= in_bit;
         synced_q <= sync1_q;
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            stable_q <= 1'b0;
         end else begin
            stable_q <= synced_q;
         end
      end
   end else begin : g_count
      localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

      logic [CntW-1:0] cnt_q;

      // Counter only runs while synced differs from stable, so any return to
      // the accepted level restarts the qualification window.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
         end else if (synced_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntLast) begin
            cnt_q    <= '0;
            stable_q <= synced_q;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with debounce, edge capture and maskable level interrupt.
//   clk, reset_n : system clock, asynchronous active-low reset
//   address      : word select (0 DATA, 2 IRQMASK, 3 EDGECAPTURE, 1 reads 0)
//   chipselect   : slave select
//   write        : write strobe, qualified by chipselect
//   writedata    : write data
//   in_port      : raw asynchronous inputs
//   readdata     : registered read data, 1 clock latency, unused bits zero
//   irq          : registered level interrupt, |(edgecapture & irqmask)
module pio_in_edge_irq
   import pio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EDGE_MODE       = 0,
   parameter logic [31:0] IRQ_RESET_MASK  = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] stable;
   logic [DATA_WIDTH-1:0] stable_d_q;
   logic [DATA_WIDTH-1:0] edge_event;
   logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
   logic [DATA_WIDTH-1:0] irqmask_q;
   logic [DATA_WIDTH-1:0] clear_mask;
   logic [31:0]           rd_mux;
   logic [31:0]           readdata_q;
   logic                  irq_q;
   logic                  wr_edgecap;
   logic                  wr_irqmask;
   logic                  unused_wdata;

   // Only the low DATA_WIDTH bits of writedata are meaningful.
   assign unused_wdata = ^writedata;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .in_bit  (in_port[i]),
         .stable  (stable[i])
      );
   end

   always_comb begin
      edge_event = '0;
      case (EDGE_MODE)
         EDGE_RISE: edge_event = stable & ~stable_d_q;
         EDGE_FALL: edge_event = ~stable & stable_d_q;
         default:   edge_event = stable ^ stable_d_q;
      endcase
   end

   assign wr_edgecap = chipselect & write & (address == ADDR_EDGECAP);
   assign wr_irqmask = chipselect & write & (address == ADDR_IRQMASK);
   assign clear_mask = wr_edgecap ? writedata[DATA_WIDTH-1:0] : '0;

   // A new event in the same clock as a write-1-to-clear keeps the bit set.
   assign edgecap_d = (edgecap_q & ~clear_mask) | edge_event;

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = stable;
         ADDR_IRQMASK: rd_mux[DATA_WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: rd_mux[DATA_WIDTH-1:0] = edgecap_q;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d_q <= '0;
         edgecap_q  <= '0;
         irqmask_q  <= IRQ_RESET_MASK[DATA_WIDTH-1:0];
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         stable_d_q <= stable;
         edgecap_q  <= edgecap_d;
         if (wr_irqmask) begin
            irqmask_q <= writedata[DATA_WIDTH-1:0];
         end
         // Read data is registered every clock, independent of chipselect.
         readdata_q <= rd_mux;
         irq_q      <= |(edgecap_q & irqmask_q);
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: a rising-edge instance with a 4-clock
// debounce and a falling-edge instance with debounce bypassed share one bus.
module tb_pio_in_edge_irq;
   import pio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = 32'h0;
   logic [7:0]  in_a = 8'h00;
   logic [7:0]  in_b = 8'h00;
   logic [31:0] rd_a, rd_b;
   logic        irq_a, irq_b;
   logic [31:0] va, vb;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pio_in_edge_irq #(
      .DATA_WIDTH      (8),
      .DEBOUNCE_CYCLES (4),
      .EDGE_MODE       (EDGE_RISE),
      .IRQ_RESET_MASK  (32'h0)
   ) dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .in_port    (in_a),
      .readdata   (rd_a),
      .irq        (irq_a)
   );

   pio_in_edge_irq #(
      .DATA_WIDTH      (8),
      .DEBOUNCE_CYCLES (0),
      .EDGE_MODE       (EDGE_FALL),
      .IRQ_RESET_MASK  (32'h0)
   ) dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .in_port    (in_b),
      .readdata   (rd_b),
      .irq        (irq_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      step(1);
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] ra, output logic [31:0] rb);
      address    = a;
      chipselect = 1'b1;
      step(1);
      ra         = rd_a;
      rb         = rd_b;
      chipselect = 1'b0;
   endtask

   initial begin
      // 1. reset / idle
      step(3);
      check("rst_irq", {31'b0, irq_a}, 32'h0);
      check("rst_rd", rd_a, 32'h0);
      reset_n = 1'b1;
      step(2);
      for (int a = 0; a < 4; a++) begin
         bus_rd(a[1:0], va, vb);
         check($sformatf("idle_rd%0d", a), va, 32'h0);
      end
      check("idle_irq", {31'b0, irq_a}, 32'h0);

      // 2. step to 0xA5: 2 sync + 4 debounce + 1 read clock
      address = ADDR_DATA;
      in_a    = 8'hA5;
      step(6);
      check("data_early", rd_a, 32'h0);
      step(1);
      check("data_a5", rd_a, 32'hA5);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("edgecap_a5", va, 32'hA5);
      check("irq_masked", {31'b0, irq_a}, 32'h0);
      bus_wr(ADDR_EDGECAP, 32'hFF);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("edgecap_clr", va, 32'h0);

      // 3. glitch rejection then acceptance on bit0
      in_a = 8'h00;
      step(10);
      bus_wr(ADDR_EDGECAP, 32'hFF);
      in_a = 8'h01;
      step(3);
      in_a = 8'h00;
      step(10);
      bus_rd(ADDR_DATA, va, vb);
      check("glitch3_data", va, 32'h0);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("glitch3_edge", va, 32'h0);
      address = ADDR_DATA;
      in_a    = 8'h01;
      step(4);
      in_a = 8'h00;
      step(4);
      check("glitch4_data", rd_a, 32'h01);
      step(10);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("glitch4_edge", va, 32'h01);

      // 4. interrupt path
      bus_wr(ADDR_EDGECAP, 32'hFF);
      bus_wr(ADDR_IRQMASK, 32'h01);
      step(2);
      check("irq_idle", {31'b0, irq_a}, 32'h0);
      in_a = 8'h01;
      step(10);
      check("irq_set", {31'b0, irq_a}, 32'h1);
      bus_rd(ADDR_IRQMASK, va, vb);
      check("mask_rd", va, 32'h01);
      bus_wr(ADDR_EDGECAP, 32'h01);
      step(1);
      check("irq_clr", {31'b0, irq_a}, 32'h0);
      in_a = 8'h81;
      step(10);
      check("irq_bit7_masked", {31'b0, irq_a}, 32'h0);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("edgecap_bit7", va, 32'h80);

      // 5. set wins over clear in the same clock (edge captured on edge 7)
      in_a = 8'h85;
      step(6);
      bus_wr(ADDR_EDGECAP, 32'h04);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("set_wins", va, 32'h84);
      check("irq_pre_mask", {31'b0, irq_a}, 32'h0);
      bus_wr(ADDR_IRQMASK, 32'h84);
      step(1);
      check("irq_mask_on", {31'b0, irq_a}, 32'h1);
      bus_wr(ADDR_EDGECAP, 32'h04);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("clr_bit2", va, 32'h80);

      // 6. falling-edge instance, debounce bypassed
      in_b = 8'hFF;
      step(10);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("b_no_rise", vb, 32'h0);
      address = ADDR_EDGECAP;
      in_b    = 8'h0F;
      step(4);
      check("b_edge_early", rd_b, 32'h0);
      step(1);
      check("b_edge_f0", rd_b, 32'hF0);
      bus_wr(ADDR_IRQMASK, 32'hF0);
      step(1);
      check("b_irq", {31'b0, irq_b}, 32'h1);
      check("a_irq_pre_rst", {31'b0, irq_a}, 32'h1);

      // reset mid-debounce on dut_a
      in_a = 8'h00;
      step(3);
      reset_n = 1'b0;
      #1;
      check("rst_irq_a", {31'b0, irq_a}, 32'h0);
      check("rst_irq_b", {31'b0, irq_b}, 32'h0);
      check("rst_rd_a", rd_a, 32'h0);
      check("rst_rd_b", rd_b, 32'h0);
      step(2);
      reset_n = 1'b1;
      step(10);
      bus_rd(ADDR_IRQMASK, va, vb);
      check("rst_mask_a", va, 32'h0);
      check("rst_mask_b", vb, 32'h0);
      bus_rd(ADDR_EDGECAP, va, vb);
      check("rst_edge_a", va, 32'h0);
      check("rst_edge_b", vb, 32'h0);
      bus_rd(ADDR_DATA, va, vb);
      check("rst_data_a", va, 32'h0);
      check("rst_data_b", vb, 32'h0F);
      check("rst_irq_a_end", {31'b0, irq_a}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
